// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: DEPTH-entry circular snapshot buffer of CPU state, drained oldest-first
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_start_cpu           run enable; low clears the buffer and returns to idle
//   ctrl_step_execution   step-mode indicator (gates strobes when STEP_ONLY=1)
//   i_user_sample         one-cycle capture strobe
//   i_halt                CU halt level; its rising edge forces a final capture and freezes
//   i_pc/i_opcode/i_acc/i_mr/i_flags  architectural taps
//   i_rd_en               pop request
//   o_rd_valid, o_rd_*    one-cycle pulse with the popped entry (fields hold until next pop)
//   o_count/o_empty/o_full  occupancy
//   o_overflow            sticky: a capture was dropped or overwrote the oldest entry
//   o_frozen              halt capture taken, no further captures
module cpu_trace_buffer #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 8,
    parameter int OP_W      = 8,
    parameter int FLAG_W    = 5,
    parameter int DEPTH     = 16,
    parameter bit WRAP      = 1'b1,
    parameter bit STEP_ONLY = 1'b1
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_start_cpu,
    input  logic                       ctrl_step_execution,
    input  logic                       i_user_sample,
    input  logic                       i_halt,
    input  logic [ADDR_W-1:0]          i_pc,
    input  logic [OP_W-1:0]            i_opcode,
    input  logic [DATA_W-1:0]          i_acc,
    input  logic [DATA_W-1:0]          i_mr,
    input  logic [FLAG_W-1:0]          i_flags,
    input  logic                       i_rd_en,
    output logic                       o_rd_valid,
    output logic [ADDR_W-1:0]          o_rd_pc,
    output logic [OP_W-1:0]            o_rd_opcode,
    output logic [DATA_W-1:0]          o_rd_acc,
    output logic [DATA_W-1:0]          o_rd_mr,
    output logic [FLAG_W-1:0]          o_rd_flags,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_empty,
    output logic                       o_full,
    output logic                       o_overflow,
    output logic                       o_frozen
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int EW = ADDR_W + OP_W + 2*DATA_W + FLAG_W;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] FROZEN = 2'd2;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [EW-1:0] mem_q [DEPTH];
    logic [1:0]    state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [EW-1:0] rd_data_q, rd_data_d;
    logic          ovf_q, ovf_d, frozen_q, frozen_d, rd_valid_q, rd_valid_d, halt_q;
    logic          full, halt_rise, cap, pop, write;

    always_comb begin
        full      = count_q == FULL_CNT;
        halt_rise = i_halt & ~halt_q;
        cap       = (state_q == RUN) & ((i_user_sample & (ctrl_step_execution | ~STEP_ONLY)) | halt_rise);
        pop       = i_rd_en & (count_q != '0);
        // A full buffer still accepts the capture when a pop frees a slot or when wrapping.
        write     = i_start_cpu & cap & (~full | pop | WRAP);
        state_d    = IDLE;
        wr_ptr_d   = '0;
        rd_ptr_d   = '0;
        count_d    = '0;
        ovf_d      = 1'b0;
        frozen_d   = 1'b0;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        if (i_start_cpu) begin
            state_d    = (state_q == IDLE) ? RUN : (cap & halt_rise) ? FROZEN : state_q;
            wr_ptr_d   = write ? wr_ptr_q + PTR_ONE : wr_ptr_q;
            // Overwriting a full buffer discards the oldest entry, so the read side advances too.
            rd_ptr_d   = (pop | (write & full)) ? rd_ptr_q + PTR_ONE : rd_ptr_q;
            count_d    = (cap & ~pop & ~full) ? count_q + CNT_ONE : (pop & ~cap) ? count_q - CNT_ONE : count_q;
            ovf_d      = ovf_q | (cap & full & ~pop);
            frozen_d   = frozen_q | (cap & halt_rise);
            rd_valid_d = pop;
            rd_data_d  = pop ? mem_q[rd_ptr_q] : rd_data_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            frozen_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            halt_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            frozen_q   <= frozen_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            halt_q     <= i_halt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (write) mem_q[wr_ptr_q] <= {i_pc, i_opcode, i_acc, i_mr, i_flags};
    end

    assign {o_rd_pc, o_rd_opcode, o_rd_acc, o_rd_mr, o_rd_flags} = rd_data_q;
    assign o_rd_valid = rd_valid_q;
    assign o_count    = count_q;
    assign o_empty    = count_q == '0;
    assign o_full     = full;
    assign o_overflow = ovf_q;
    assign o_frozen   = frozen_q;
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb_cpu_trace_buffer: checks a wrapping and a dropping buffer against a queue model plus directed literals
module tb_cpu_trace_buffer;
    logic clk = 1'b0, rst_n = 1'b0;
    logic start = 1'b0, step = 1'b0, samp = 1'b0, halt = 1'b0, rd = 1'b0;
    logic [7:0] pc = '0, op = '0;
    logic [15:0] acc = '0, mr = '0;
    logic [4:0] fl = '0;
    logic rv [2];
    logic [7:0] rpc [2];
    logic [7:0] rop [2];
    logic [15:0] racc [2];
    logic [15:0] rmr [2];
    logic [4:0] rfl [2];
    logic [4:0] cnt [2];
    logic emp [2];
    logic full [2];
    logic ovf [2];
    logic froz [2];
    int tests = 0, fails = 0;
    bit chk = 0;

    always #5 clk = ~clk;

    cpu_trace_buffer #(.WRAP(1'b1)) dut_w (
        .i_clk(clk), .i_rst_n(rst_n), .i_start_cpu(start), .ctrl_step_execution(step),
        .i_user_sample(samp), .i_halt(halt), .i_pc(pc), .i_opcode(op), .i_acc(acc), .i_mr(mr),
        .i_flags(fl), .i_rd_en(rd), .o_rd_valid(rv[0]), .o_rd_pc(rpc[0]), .o_rd_opcode(rop[0]),
        .o_rd_acc(racc[0]), .o_rd_mr(rmr[0]), .o_rd_flags(rfl[0]), .o_count(cnt[0]),
        .o_empty(emp[0]), .o_full(full[0]), .o_overflow(ovf[0]), .o_frozen(froz[0]));

    cpu_trace_buffer #(.WRAP(1'b0)) dut_d (
        .i_clk(clk), .i_rst_n(rst_n), .i_start_cpu(start), .ctrl_step_execution(step),
        .i_user_sample(samp), .i_halt(halt), .i_pc(pc), .i_opcode(op), .i_acc(acc), .i_mr(mr),
        .i_flags(fl), .i_rd_en(rd), .o_rd_valid(rv[1]), .o_rd_pc(rpc[1]), .o_rd_opcode(rop[1]),
        .o_rd_acc(racc[1]), .o_rd_mr(rmr[1]), .o_rd_flags(rfl[1]), .o_count(cnt[1]),
        .o_empty(emp[1]), .o_full(full[1]), .o_overflow(ovf[1]), .o_frozen(froz[1]));

    logic [52:0] q0 [$];
    logic [52:0] q1 [$];
    int mode [2];
    logic hprev [2];
    logic movf [2];
    logic mrv [2];
    logic [52:0] mrd [2];

    function automatic int qsize(input int m);
        return m == 0 ? q0.size() : q1.size();
    endfunction

    task automatic qpush(input int m, input logic [52:0] e);
        if (m == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic qpop(input int m, output logic [52:0] e);
        if (m == 0) e = q0.pop_front(); else e = q1.pop_front();
    endtask

    task automatic mreset(input int m);
        if (m == 0) q0.delete(); else q1.delete();
        mode[m] = 0;
        hprev[m] = 1'b0;
        movf[m] = 1'b0;
        mrv[m] = 1'b0;
        mrd[m] = '0;
    endtask

    task automatic mstep(input int m, input bit wrap);
        logic [52:0] t;
        bit hr, cap, pop;
        hr = halt && !hprev[m];
        hprev[m] = halt;
        if (!start) begin
            if (m == 0) q0.delete(); else q1.delete();
            movf[m] = 1'b0;
            mrv[m] = 1'b0;
            mode[m] = 0;
        end else if (mode[m] == 0) begin
            mode[m] = 1;
            mrv[m] = 1'b0;
        end else begin
            cap = mode[m] == 1 && ((samp && step) || hr);
            pop = rd && qsize(m) > 0;
            mrv[m] = pop;
            if (pop) begin
                qpop(m, t);
                mrd[m] = t;
            end
            if (cap) begin
                if (qsize(m) < 16) qpush(m, {pc, op, acc, mr, fl});
                else begin
                    movf[m] = 1'b1;
                    if (wrap) begin
                        qpop(m, t);
                        qpush(m, {pc, op, acc, mr, fl});
                    end
                end
                if (hr) mode[m] = 2;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mreset(0);
            mreset(1);
        end else begin
            mstep(0, 1'b1);
            mstep(1, 1'b0);
        end
    end

    task automatic check(input string n, input logic [63:0] a, input logic [63:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    task automatic cmp(input int m);
        check($sformatf("m%0d rd_valid", m), 64'(rv[m]), 64'(mrv[m]));
        check($sformatf("m%0d rd_data", m), 64'({rpc[m], rop[m], racc[m], rmr[m], rfl[m]}), 64'(mrd[m]));
        check($sformatf("m%0d count", m), 64'(cnt[m]), 64'(qsize(m)));
        check($sformatf("m%0d empty", m), 64'(emp[m]), 64'(qsize(m) == 0));
        check($sformatf("m%0d full", m), 64'(full[m]), 64'(qsize(m) == 16));
        check($sformatf("m%0d overflow", m), 64'(ovf[m]), 64'(movf[m]));
        check($sformatf("m%0d frozen", m), 64'(froz[m]), 64'(mode[m] == 2));
    endtask

    always @(negedge clk) begin
        if (rst_n && chk) begin
            cmp(0);
            cmp(1);
        end
    end

    task automatic cyc(input bit s, input bit r, input logic [7:0] p);
        samp = s;
        rd = r;
        pc = p;
        op = ~p;
        acc = {p, 8'h5A};
        mr = {8'hC3, p};
        fl = p[4:0];
        @(negedge clk);
    endtask

    task automatic restart();
        start = 1'b0;
        cyc(0, 0, 8'h00);
        start = 1'b1;
        cyc(0, 0, 8'h00);
    endtask

    initial begin
        step = 1'b1;
        repeat (2) @(negedge clk);
        check("reset count", 64'(cnt[0]), 64'd0);
        check("reset empty", 64'(emp[0]), 64'd1);
        check("reset valid/full/ovf/frozen", 64'({rv[0], full[0], ovf[0], froz[0]}), 64'd0);
        rst_n = 1'b1;
        chk = 1;
        restart();
        // T1: three strobes drained in order
        for (int i = 1; i <= 3; i++) cyc(1, 0, 8'(i));
        check("t1 count", 64'(cnt[0]), 64'd3);
        for (int i = 1; i <= 3; i++) begin
            cyc(0, 1, 8'h00);
            check("t1 pop valid", 64'(rv[0]), 64'd1);
            check("t1 pop pc", 64'(rpc[0]), 64'(i));
        end
        check("t1 empty", 64'(emp[0]), 64'd1);
        cyc(0, 0, 8'h00);
        check("t1 valid drops", 64'(rv[0]), 64'd0);
        // T2/T3: 18 strobes into both wrap policies
        restart();
        for (int i = 0; i < 18; i++) cyc(1, 0, 8'(i));
        check("t2 count wrap", 64'(cnt[0]), 64'd16);
        check("t3 count drop", 64'(cnt[1]), 64'd16);
        check("t2 ovf wrap", 64'(ovf[0]), 64'd1);
        check("t3 ovf drop", 64'(ovf[1]), 64'd1);
        for (int i = 0; i < 16; i++) begin
            cyc(0, 1, 8'h00);
            if (i == 0) begin
                check("t2 first pc", 64'(rpc[0]), 64'd2);
                check("t3 first pc", 64'(rpc[1]), 64'd0);
            end
            if (i == 15) begin
                check("t2 last pc", 64'(rpc[0]), 64'd17);
                check("t3 last pc", 64'(rpc[1]), 64'd15);
            end
        end
        // T4: halt rising edge forces a capture and freezes
        restart();
        cyc(1, 0, 8'h10);
        cyc(1, 0, 8'h11);
        halt = 1'b1;
        cyc(0, 0, 8'h2A);
        check("t4 frozen", 64'(froz[0]), 64'd1);
        check("t4 count", 64'(cnt[0]), 64'd3);
        cyc(1, 0, 8'h30);
        cyc(1, 0, 8'h31);
        halt = 1'b0;
        cyc(1, 0, 8'h32);
        check("t4 count held", 64'(cnt[0]), 64'd3);
        for (int i = 0; i < 3; i++) cyc(0, 1, 8'h00);
        check("t4 halt entry pc", 64'(rpc[0]), 64'h2A);
        check("t4 halt entry acc", 64'(racc[0]), 64'h2A5A);
        // T5: full buffer, strobe and pop together; then empty buffer, strobe and pop together
        restart();
        for (int i = 0; i < 16; i++) cyc(1, 0, 8'(8'h40 + i));
        cyc(1, 1, 8'h50);
        check("t5 pop oldest wrap", 64'(rpc[0]), 64'h40);
        check("t5 pop oldest drop", 64'(rpc[1]), 64'h40);
        check("t5 count", 64'(cnt[1]), 64'd16);
        check("t5 ovf clear", 64'({ovf[0], ovf[1]}), 64'd0);
        for (int i = 0; i < 16; i++) cyc(0, 1, 8'h00);
        check("t5 drained last", 64'(rpc[1]), 64'h50);
        cyc(1, 1, 8'h60);
        check("t5 empty pop ignored", 64'(rv[0]), 64'd0);
        check("t5 empty count", 64'(cnt[0]), 64'd1);
        // T6: drop start with entries, overflow and frozen set
        restart();
        for (int i = 0; i < 18; i++) cyc(1, 0, 8'(i));
        for (int i = 0; i < 12; i++) cyc(0, 1, 8'h00);
        halt = 1'b1;
        cyc(0, 0, 8'h77);
        halt = 1'b0;
        check("t6 count before", 64'(cnt[0]), 64'd5);
        check("t6 ovf/frozen before", 64'({ovf[0], froz[0]}), 64'b11);
        start = 1'b0;
        cyc(0, 0, 8'h00);
        check("t6 count cleared", 64'(cnt[0]), 64'd0);
        check("t6 empty", 64'(emp[0]), 64'd1);
        check("t6 ovf/frozen cleared", 64'({ovf[0], froz[0], ovf[1], froz[1]}), 64'd0);
        start = 1'b1;
        cyc(0, 0, 8'h00);
        cyc(1, 0, 8'h01);
        cyc(1, 0, 8'h02);
        cyc(0, 1, 8'h00);
        check("t6 pop before reset", 64'(rv[0]), 64'd1);
        rd = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t6 async reset valid", 64'({rv[0], rv[1]}), 64'd0);
        check("t6 async reset count", 64'(cnt[0]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 0, 8'h00);
        cyc(0, 0, 8'h00);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
